dumbrv_memseq: RTL

//  Sits between the core's load/store unit and the byte-wide SPI memory

---
 rtl/dumbrv_memseq_if.sv | 58 +++++
 rtl/dumbrv_memseq.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/dumbrv_memseq_if.sv
// Bundle between the load/store unit, the byte sequencer and the byte-wide SPI memory port.
// master = core + SPI side (drives requests and byte completions); slave = the sequencer.
interface dumbrv_memseq_if;
  // core request / response
  logic        req_valid;
  logic        req_ready;
  logic        req_wr;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [15:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;

  // byte requests toward the SPI memory port
  logic        mem_valid;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_done;
  logic [7:0]  mem_rdata;

  modport slave (
    input  req_valid,
    output req_ready,
    input  req_wr,
    input  req_size,
    input  req_signed,
    input  req_addr,
    input  req_wdata,
    output resp_valid,
    output resp_rdata,
    output mem_valid,
    output mem_wr,
    output mem_addr,
    output mem_wdata,
    input  mem_done,
    input  mem_rdata
  );

  modport master (
    output req_valid,
    input  req_ready,
    output req_wr,
    output req_size,
    output req_signed,
    output req_addr,
    output req_wdata,
    input  resp_valid,
    input  resp_rdata,
    input  mem_valid,
    input  mem_wr,
    input  mem_addr,
    input  mem_wdata,
    output mem_done,
    output mem_rdata
  );
endinterface

// File: rtl/dumbrv_memseq.sv
// Splits byte/half/word core accesses into ascending byte transactions for the SPI port,
// assembling load bytes little-endian and extending them into one 32-bit response.
module dumbrv_memseq #(
  parameter int GAP_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  dumbrv_memseq_if.slave   bus
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_GAP,
    ST_RESP
  } state_e;

  state_e state_q, state_d;

  // latched request
  logic        wr_q, wr_d;
  logic [1:0]  size_q, size_d;
  logic        signed_q, signed_d;
  logic [15:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;

  // byte sequencing
  logic [1:0]       idx_q, idx_d;
  logic [1:0]       last_q, last_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [31:0]      asm_q, asm_d;

  // registered outputs
  logic        mem_valid_q, mem_valid_d;
  logic        mem_wr_q, mem_wr_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic [7:0]  mem_wdata_q, mem_wdata_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;

  logic [7:0]  wbyte [4];
  logic [31:0] asm_cap;

  // Byte lanes: store-data slices and the assembly register with the current read byte merged in.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign wbyte[gi]          = wdata_q[8*gi +: 8];
    assign asm_cap[8*gi +: 8] = (idx_q == 2'(gi)) ? bus.mem_rdata : asm_q[8*gi +: 8];
  end

  function automatic logic [31:0] extend_load(input logic [31:0] v,
                                              input logic [1:0]  sz,
                                              input logic        sgn);
    logic [31:0] r;
    r = v;
    case (sz)
      2'd0:    r = {{24{sgn & v[7]}},  v[7:0]};
      2'd1:    r = {{16{sgn & v[15]}}, v[15:0]};
      default: r = v;
    endcase
    return r;
  endfunction

  always_comb begin
    state_d      = state_q;
    wr_d         = wr_q;
    size_d       = size_q;
    signed_d     = signed_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    idx_d        = idx_q;
    last_d       = last_q;
    gap_cnt_d    = gap_cnt_q;
    asm_d        = asm_q;
    mem_valid_d  = mem_valid_q;
    mem_wr_d     = mem_wr_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          wr_d      = bus.req_wr;
          size_d    = bus.req_size;
          signed_d  = bus.req_signed;
          addr_d    = bus.req_addr;
          wdata_d   = bus.req_wdata;
          idx_d     = 2'd0;
          gap_cnt_d = '0;
          asm_d     = 32'd0;
          case (bus.req_size)
            2'd0:    last_d = 2'd0;
            2'd1:    last_d = 2'd1;
            default: last_d = 2'd3;
          endcase
          // First byte is presented straight from the request inputs.
          mem_valid_d = 1'b1;
          mem_wr_d    = bus.req_wr;
          mem_addr_d  = bus.req_addr;
          mem_wdata_d = bus.req_wdata[7:0];
          state_d     = ST_REQ;
        end
      end

      ST_REQ: begin
        if (bus.mem_done) begin
          if (!wr_q) begin
            asm_d = asm_cap;
          end
          mem_valid_d = 1'b0;
          if (idx_q == last_q) begin
            resp_valid_d = 1'b1;
            resp_rdata_d = wr_q ? 32'd0 : extend_load(asm_cap, size_q, signed_q);
            state_d      = ST_RESP;
          end else begin
            idx_d     = idx_q + 2'd1;
            gap_cnt_d = '0;
            state_d   = ST_GAP;
          end
        end
      end

      ST_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          // idx already points at the next byte; address wraps naturally at 16 bits.
          mem_valid_d = 1'b1;
          mem_addr_d  = addr_q + {14'd0, idx_q};
          mem_wdata_d = wbyte[idx_q];
          state_d     = ST_REQ;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d     = ST_IDLE;
        mem_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      wr_q         <= 1'b0;
      size_q       <= 2'd0;
      signed_q     <= 1'b0;
      addr_q       <= 16'd0;
      wdata_q      <= 32'd0;
      idx_q        <= 2'd0;
      last_q       <= 2'd0;
      gap_cnt_q    <= '0;
      asm_q        <= 32'd0;
      mem_valid_q  <= 1'b0;
      mem_wr_q     <= 1'b0;
      mem_addr_q   <= 16'd0;
      mem_wdata_q  <= 8'd0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'd0;
    end else begin
      state_q      <= state_d;
      wr_q         <= wr_d;
      size_q       <= size_d;
      signed_q     <= signed_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      idx_q        <= idx_d;
      last_q       <= last_d;
      gap_cnt_q    <= gap_cnt_d;
      asm_q        <= asm_d;
      mem_valid_q  <= mem_valid_d;
      mem_wr_q     <= mem_wr_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  assign bus.req_ready  = (state_q == ST_IDLE);
  assign bus.mem_valid  = mem_valid_q;
  assign bus.mem_wr     = mem_wr_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;

endmodule
